// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin data memory arbiter with access checking
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_funct3,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_funct3,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        accept;

  logic        idx_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        bad_q;

  logic [31:0] rdata0_q, rdata1_q;
  logic        err0_q, err1_q;
  logic [7:0]  err_count_q;

  logic        any_req;
  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_funct3;
  logic        sel_bad;

  // Illegal size code, misalignment, or an access whose last byte lies past
  // the end of memory. The end address is formed in 33 bits so that an access
  // near 0xFFFFFFFF cannot wrap back into range.
  function automatic logic cmd_bad(input logic f_we, input logic [31:0] f_addr,
                                   input logic [2:0] f_funct3);
    logic       bad;
    logic [2:0] sz;
    logic [32:0] end_excl;
    bad = 1'b0;
    sz  = 3'd0;
    case (f_funct3)
      3'b000: sz = 3'd1;
      3'b001: begin
        sz  = 3'd2;
        bad = f_addr[0];
      end
      3'b010: begin
        sz  = 3'd4;
        bad = (f_addr[1:0] != 2'b00);
      end
      3'b100: begin
        sz  = 3'd1;
        bad = f_we;
      end
      3'b101: begin
        sz  = 3'd2;
        bad = f_we | f_addr[0];
      end
      default: bad = 1'b1;
    endcase
    end_excl = {1'b0, f_addr} + {30'd0, sz};
    if (end_excl > 33'(MEM_BYTES)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  // Round-robin choice: on contention the requester that did not win last time.
  assign any_req    = m0_req | m1_req;
  assign win        = (m0_req & m1_req) ? ~last_q : m1_req;
  assign sel_we     = win ? m1_we     : m0_we;
  assign sel_addr   = win ? m1_addr   : m0_addr;
  assign sel_wdata  = win ? m1_wdata  : m0_wdata;
  assign sel_funct3 = win ? m1_funct3 : m0_funct3;
  assign sel_bad    = cmd_bad(sel_we, sel_addr, sel_funct3);

  // Next-state logic: erroneous requests skip the memory cycle entirely.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          last_d  = win;
          state_d = sel_bad ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer; after reset requester 0 wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Latch the winning command so requesters cannot disturb an access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      bad_q    <= 1'b0;
    end else if (accept) begin
      idx_q    <= win;
      we_q     <= sel_we;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
      funct3_q <= sel_funct3;
      bad_q    <= sel_bad;
    end
  end

  // Per-requester response registers; only the winner's pair is ever touched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else if (accept) begin
      if (win) begin
        err1_q <= sel_bad;
        if (sel_bad) rdata1_q <= 32'd0;
      end else begin
        err0_q <= sel_bad;
        if (sel_bad) rdata0_q <= 32'd0;
      end
    end else if (state_q == ACCESS) begin
      if (idx_q) rdata1_q <= we_q ? 32'd0 : mem_read_data;
      else       rdata0_q <= we_q ? 32'd0 : mem_read_data;
    end
  end

  // Saturating count of error responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 8'd0;
    end else if ((state_q == RESP) && bad_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  // Output decode; reset forces every output low, including a store in flight.
  always_comb begin
    m0_gnt         = 1'b0;
    m1_gnt         = 1'b0;
    m0_done        = 1'b0;
    m1_done        = 1'b0;
    m0_rdata       = 32'd0;
    m1_rdata       = 32'd0;
    m0_err         = 1'b0;
    m1_err         = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    mem_funct3     = 3'd0;
    err_count      = 8'd0;
    if (!rst) begin
      if (state_q == ACCESS) begin
        mem_read       = ~we_q;
        mem_write      = we_q;
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_funct3     = funct3_q;
        m0_gnt         = ~idx_q;
        m1_gnt         = idx_q;
      end
      if (state_q == RESP) begin
        m0_done = ~idx_q;
        m1_done = idx_q;
      end
      m0_rdata  = rdata0_q;
      m1_rdata  = rdata1_q;
      m0_err    = err0_q;
      m1_err    = err1_q;
      err_count = err_count_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_funct3, m1_funct3;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [2:0]  mem_funct3;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;
  int strobes = 0;

  logic [7:0]  mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [7:0]  pl_data;

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_done(m1_done),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_funct3(mem_funct3),
    .mem_read_data(mem_read_data), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: combinational formatted read, store or preload at the edge.
  always_comb begin
    logic [9:0] a;
    logic [7:0] b0, b1, b2, b3;
    a  = mem_address[9:0];
    b0 = mem[a];
    b1 = mem[a + 10'd1];
    b2 = mem[a + 10'd2];
    b3 = mem[a + 10'd3];
    case (mem_funct3)
      3'b000:  mem_read_data = {{24{b0[7]}}, b0};
      3'b001:  mem_read_data = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_read_data = {b3, b2, b1, b0};
      3'b100:  mem_read_data = {24'd0, b0};
      3'b101:  mem_read_data = {16'd0, b1, b0};
      default: mem_read_data = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_read | mem_write) strobes <= strobes + 1;
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_write) begin
      mem[mem_address[9:0]] <= mem_write_data[7:0];
      if (mem_funct3 != 3'b000) mem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[mem_address[9:0] + 10'd2] <= mem_write_data[23:16];
        mem[mem_address[9:0] + 10'd3] <= mem_write_data[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input int who, input logic r, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (who == 0) begin
      m0_req = r; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_funct3 = f3;
    end else begin
      m1_req = r; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_funct3 = f3;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request from one requester; lat/gnt_at are cycles after the sampling edge (0 = never).
  task automatic do_req(input int who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat, output int gnt_at);
    lat = 0; gnt_at = 0; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    drive(who, 1'b1, we, addr, wd, f3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (gnt_at == 0 && ((who == 0) ? m0_gnt : m1_gnt)) gnt_at = k;
      if ((who == 0) ? m0_done : m1_done) begin
        rd  = (who == 0) ? m0_rdata : m1_rdata;
        er  = (who == 0) ? m0_err : m1_err;
        lat = k;
        break;
      end
    end
    drive(who, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, gat, s0;

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    preload(10'h010, 8'h11); preload(10'h011, 8'h22);
    preload(10'h012, 8'h33); preload(10'h013, 8'h44);
    preload(10'h030, 8'h80); preload(10'h031, 8'hF0);
    preload(10'h040, 8'h00); preload(10'h041, 8'h00);
    preload(10'h042, 8'hAA); preload(10'h043, 8'hBB);
    preload(10'h3FC, 8'h01); preload(10'h3FD, 8'h02);
    preload(10'h3FE, 8'h03); preload(10'h3FF, 8'h04);
    preload(10'h050, 8'h00); preload(10'h051, 8'h00);
    preload(10'h052, 8'h00); preload(10'h053, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outs", {m0_gnt, m1_gnt, m0_done, m1_done, mem_read, mem_write, m0_err, m1_err}, 32'd0);
    check("reset_errcnt", {24'd0, err_count}, 32'd0);
    check("reset_rdata", m0_rdata | m1_rdata | mem_address, 32'd0);

    // Single word load
    do_req(0, 1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat, gat);
    check("lw_rdata", rd, 32'h44332211);
    check("lw_err", {31'd0, er}, 32'd0);
    check("lw_lat", lat, 2);
    check("lw_gnt_at", gat, 1);

    // Sign and zero extension of sub-word loads
    do_req(1, 1'b0, 32'h30, 32'd0, 3'b000, rd, er, lat, gat);
    check("lb_rdata", rd, 32'hFFFFFF80);
    do_req(1, 1'b0, 32'h30, 32'd0, 3'b100, rd, er, lat, gat);
    check("lbu_rdata", rd, 32'h00000080);
    do_req(1, 1'b0, 32'h30, 32'd0, 3'b001, rd, er, lat, gat);
    check("lh_rdata", rd, 32'hFFFFF080);
    do_req(1, 1'b0, 32'h30, 32'd0, 3'b101, rd, er, lat, gat);
    check("lhu_rdata", rd, 32'h0000F080);

    // Halfword store then word readback
    do_req(0, 1'b1, 32'h40, 32'h12345678, 3'b001, rd, er, lat, gat);
    check("sh_rdata", rd, 32'd0);
    check("sh_lat", lat, 2);
    do_req(0, 1'b0, 32'h40, 32'd0, 3'b010, rd, er, lat, gat);
    check("sh_readback", rd, 32'hBBAA5678);

    // Contention held through reset release
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 3'b010);
    drive(1, 1'b1, 1'b0, 32'h23, 32'd0, 3'b100);
    @(negedge clk);
    check("rst_gnt_low", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int d0, d1;
      logic [31:0] r1;
      d0 = 0; d1 = 0; r1 = 32'd0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (m0_done && d0 == 0) begin d0 = k; m0_req = 1'b0; end
        if (m1_done && d1 == 0) begin d1 = k; r1 = m1_rdata; m1_req = 1'b0; end
        if (d0 != 0 && d1 != 0) break;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      check("cont_m0_done_at", d0, 2);
      check("cont_m1_done_at", d1, 5);
      check("cont_m1_rdata", r1, 32'h000000DE);
      check("cont_mem_byte0", {24'd0, mem[10'h020]}, 32'h000000EF);
    end

    // Misaligned halfword from m1 leaves m0's response alone
    do_req(0, 1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat, gat);
    s0 = strobes;
    do_req(1, 1'b0, 32'h101, 32'd0, 3'b001, rd, er, lat, gat);
    check("mis_lat", lat, 1);
    check("mis_err", {31'd0, er}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_gnt", gat, 0);
    @(negedge clk);
    check("mis_strobes", strobes - s0, 0);
    check("mis_errcnt", {24'd0, err_count}, 32'd1);
    check("mis_m0_rdata_kept", m0_rdata, 32'h44332211);

    // Range and funct3 legality
    s0 = strobes;
    do_req(0, 1'b0, 32'h3FE, 32'd0, 3'b010, rd, er, lat, gat);
    check("oor_lw3fe_err", {31'd0, er}, 32'd1);
    do_req(0, 1'b0, 32'h400, 32'd0, 3'b000, rd, er, lat, gat);
    check("oor_lb400_err", {31'd0, er}, 32'd1);
    do_req(0, 1'b1, 32'hFFFFFFFC, 32'h55, 3'b010, rd, er, lat, gat);
    check("oor_wrap_err", {31'd0, er}, 32'd1);
    check("oor_wrap_lat", lat, 1);
    do_req(0, 1'b1, 32'h44, 32'h55, 3'b100, rd, er, lat, gat);
    check("bad_store_f3", {31'd0, er}, 32'd1);
    do_req(0, 1'b0, 32'h44, 32'd0, 3'b011, rd, er, lat, gat);
    check("bad_load_f3", {31'd0, er}, 32'd1);
    @(negedge clk);
    check("oor_strobes", strobes - s0, 0);
    do_req(0, 1'b0, 32'h3FC, 32'd0, 3'b010, rd, er, lat, gat);
    check("edge_lw3fc_rdata", rd, 32'h04030201);
    check("edge_lw3fc_err", {31'd0, er}, 32'd0);
    @(negedge clk);
    check("oor_errcnt", {24'd0, err_count}, 32'd6);

    // Reset during the memory cycle of a store
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 3'b010);
    @(negedge clk);
    check("rma_in_access", {31'd0, m0_gnt & mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rma_write_gated", {31'd0, mem_write}, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (k == 1) rst = 1'b0;
        if (m0_done | m1_done) dn++;
      end
      check("rma_no_done", dn, 0);
    end
    check("rma_mem", {mem[10'h053], mem[10'h052], mem[10'h051], mem[10'h050]}, 32'd0);
    check("rma_errcnt", {24'd0, err_count}, 32'd0);
    do_req(1, 1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat, gat);
    check("rma_idle_after", lat, 2);

    // Saturation and strict alternation with both requesters always erroneous
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h1, 32'd0, 3'b001);
    drive(1, 1'b1, 1'b0, 32'h2, 32'd0, 3'b010);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int n, viol, first, prev;
      n = 0; viol = 0; first = -1; prev = -1;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        if (m0_done && m1_done) viol++;
        if (m0_done) begin
          if (prev == 0) viol++;
          if (first < 0) first = 0;
          prev = 0; n++;
        end else if (m1_done) begin
          if (prev == 1) viol++;
          if (first < 0) first = 1;
          prev = 1; n++;
        end
        if (n >= 300) break;
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(negedge clk);
      @(negedge clk);
      check("sat_count_done", n, 300);
      check("sat_alt_viol", viol, 0);
      check("sat_first_m0", first, 0);
      check("sat_errcnt", {24'd0, err_count}, 32'd255);
      check("sat_errs", {30'd0, m0_err, m1_err}, 32'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 1024: data memory size in bytes; the legal byte range is 0..MEM_BYTES-1.
REQ-002 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1: reset, synchronous and active-high.
REQ-004 Ports m0_req, m1_req  input  1 each: access request from requester 0 (core LSU) and requester 1 (DMA/debug).
REQ-005 Ports m0_we, m1_we  input  1 each: 1 = store, 0 = load.
REQ-006 Ports m0_addr, m1_addr  input  32 each: byte address.
REQ-007 Ports m0_wdata, m1_wdata  input  32 each: store data, right-aligned.
REQ-008 Ports m0_funct3, m1_funct3  input  3 each: size code; store 000/001/010 = B/H/W; load 000/001/010/100/101 = B/H/W/BU/HU.
REQ-009 Ports m0_gnt, m1_gnt  output  1 each: asserted while that requester's access owns memory.
REQ-010 Ports m0_done, m1_done  output  1 each: one-cycle completion pulse.
REQ-011 Ports m0_rdata, m1_rdata  output  32 each: load result, valid when done is high.
REQ-012 Ports m0_err, m1_err  output  1 each: error flag, valid when done is high.
REQ-013 Ports mem_read, mem_write  output  1 each: data memory strobes.
REQ-014 Ports mem_address, mem_write_data  output  32 each; mem_funct3  output  3: data memory command.
REQ-015 Port mem_read_data  input  32: combinational read data from the data memory.
REQ-016 Port err_count  output  8: saturating count of error responses.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
REQ-018 IDLE with any req high at an edge: latch the winner's we, addr, wdata, funct3 and its index; next state is ACCESS, or RESP if the request is erroneous.
REQ-019 Arbitration:
- Round-robin on register last.
- Both requests high: grant the requester != last.
- Only one request high: grant it.
- last updates to the winner on every grant.
REQ-020 The request is erroneous if any of the following holds:
- funct3 is illegal for the direction;
- halfword with addr[0] != 0;
- word with addr[1:0] != 0;
- addr + size - 1 > MEM_BYTES-1, computed without 32-bit wrap.
REQ-021 In ACCESS:
- mem_read = !we, mem_write = we & !rst;
- mem_address, mem_write_data and mem_funct3 are driven from the latched values;
- gnt of the winner is high;
- rdata_x is captured from mem_read_data at the edge;
- next state is RESP.
REQ-022 In RESP:
- done_x of the winner is high for exactly one cycle;
- err_x = 1 for erroneous requests, else 0;
- rdata_x is held;
- next state is IDLE.
REQ-023 Latency: request sampled at edge N; done at cycle N+2 for a normal access and cycle N+1 for an error.
REQ-024 Throughput: at most one access per 3 cycles; no request is accepted outside IDLE.
REQ-025 Requester protocol:
- a requester holds req and its command stable until its done;
- req still high in the cycle after done is treated as a new request.
REQ-026 Stores return rdata_x = 0; erroneous requests return rdata_x = 0 and never assert mem_read or mem_write.
REQ-027 Outside ACCESS, mem_read = mem_write = 0 and the mem_* buses are 0.
REQ-028 rdata_x and err_x of the non-winning requester are unchanged by an access.
REQ-029 err_count increments by 1 in each RESP with err, saturating at 255.
REQ-030 Fairness: with both requesters continuously requesting, grants strictly alternate.

Reset
REQ-031 rst high at an edge sets the state to IDLE, last = 1, and clears all latched command registers, rdata_x, err_x and err_count.
REQ-032 While rst is high, all outputs are 0, including mem_write during a reset cycle in ACCESS; an access interrupted by reset never produces done.
REQ-033 The first grant after reset with both requesting goes to requester 0.

Verification
REQ-034 Single load: memory bytes 0x10..0x13 = 11 22 33 44; m0 LW addr 0x10 -> m0_gnt at N+1, m0_done at N+2, m0_rdata = 0x44332211, m0_err = 0.
REQ-035 Contention: m0 SW 0x20 wdata 0xDEADBEEF and m1 LBU 0x23, both held from reset release -> m0 granted first, then m1 completes with m1_rdata = 0x000000DE.
REQ-036 Misaligned: m1 LH addr 0x101 -> m1_done at N+1, m1_err = 1, m1_rdata = 0, no mem strobes, err_count = 1.
REQ-037 Out of range, MEM_BYTES = 1024: m0 LW 0x3FE -> error; m0 SW 0xFFFFFFFC -> error, no wrap; m0 LW 0x3FC -> success.
REQ-038 Reset mid-access: rst in an ACCESS store cycle -> memory unwritten, no done, state IDLE, err_count = 0.
REQ-039 Saturation/fairness: 300 alternating erroneous requests from both requesters -> err_count = 255, and grants alternate m0, m1.
